// File: rtl/ysyx_25030077_sim_pkg.sv
// Shared types and constants for the simulation-exit monitor.
package ysyx_25030077_sim_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [7:0] EXIT_CODE_BADTRAP = 8'hFF;
    localparam logic [7:0] EXIT_CODE_TIMEOUT = 8'hFE;
    localparam logic [7:0] EXIT_CODE_HANG    = 8'hFD;

    // Watchdog causes sit just above the trap channels (1..NUM_SRC).
    localparam int CAUSE_TIMEOUT_OFS = 1;
    localparam int CAUSE_HANG_OFS    = 2;

endpackage

// File: rtl/ysyx_25030077_trap_arbiter.sv
// Fixed-priority encoder: lowest trap channel > timeout > hang.
module ysyx_25030077_trap_arbiter
    import ysyx_25030077_sim_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int CW      = $clog2(NUM_SRC + 3)
) (
    input  logic [NUM_SRC-1:0] trap_req,
    input  logic               timeout,
    input  logic               hang,
    output logic               evt_valid,
    output logic [CW-1:0]      evt_cause
);

    // Later assignments override earlier ones, so walk from lowest to highest priority.
    always_comb begin
        evt_valid = (|trap_req) | timeout | hang;
        evt_cause = '0;
        if (hang)
            evt_cause = CW'(NUM_SRC + CAUSE_HANG_OFS);
        if (timeout)
            evt_cause = CW'(NUM_SRC + CAUSE_TIMEOUT_OFS);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (trap_req[i])
                evt_cause = CW'(i + 1);
        end
    end

endmodule

// File: rtl/ysyx_25030077_sim_monitor.sv
// Simulation-exit monitor: arbitrates trap requests and watchdogs, drains,
// then halts with latched cause / exit code / PC / counters.
// Optional macro YSYX_25030077_SIM_FINISH_EN: print a summary and $finish on DONE entry.
module ysyx_25030077_sim_monitor
    import ysyx_25030077_sim_pkg::*;
#(
    parameter  int XLEN         = 32,
    parameter  int NUM_SRC      = 2,
    parameter  int HANG_LIMIT   = 1024,
    parameter  int DRAIN_CYCLES = 4,
    localparam int CW           = $clog2(NUM_SRC + 3)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic [XLEN-1:0]    a0_value,
    input  logic [NUM_SRC-1:0] trap_req,
    input  logic [63:0]        max_cycles,
    output logic               halted,
    output logic               good_trap,
    output logic [CW-1:0]      exit_cause,
    output logic [7:0]         exit_code,
    output logic [XLEN-1:0]    exit_pc,
    output logic [63:0]        cycle_cnt,
    output logic [63:0]        instr_cnt
);

    localparam int IW = $clog2(HANG_LIMIT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_e            state, next_state;
    logic [IW-1:0]     idle_cnt;
    logic [DW-1:0]     drain_cnt;
    logic [XLEN-1:0]   last_pc;
    logic              in_run;
    logic              timeout_hit;
    logic              hang_hit;
    logic              evt_valid;
    logic              evt_fire;
    logic [CW-1:0]     evt_cause;
    logic [7:0]        code_sel;
    logic              drain_last;
    logic              unused_a0_hi;

    assign unused_a0_hi = ^a0_value[XLEN-1:8];

    assign in_run      = (state == RUN);
    // cycle_cnt still holds the count before this cycle, so +1 names the current cycle.
    assign timeout_hit = (max_cycles != 64'd0) && ((cycle_cnt + 64'd1) == max_cycles);
    assign hang_hit    = !commit_valid && (idle_cnt == IW'(HANG_LIMIT - 1));
    assign drain_last  = (drain_cnt == DW'(DRAIN_CYCLES - 1));
    assign evt_fire    = in_run && evt_valid;

    ysyx_25030077_trap_arbiter #(
        .NUM_SRC (NUM_SRC),
        .CW      (CW)
    ) u_arb (
        .trap_req  (trap_req),
        .timeout   (timeout_hit),
        .hang      (hang_hit),
        .evt_valid (evt_valid),
        .evt_cause (evt_cause)
    );

    // Exit code implied by the winning cause.
    always_comb begin
        code_sel = EXIT_CODE_HANG;
        if (evt_cause == CW'(1))
            code_sel = a0_value[7:0];
        else if (evt_cause <= CW'(NUM_SRC))
            code_sel = EXIT_CODE_BADTRAP;
        else if (evt_cause == CW'(NUM_SRC + CAUSE_TIMEOUT_OFS))
            code_sel = EXIT_CODE_TIMEOUT;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= RUN;
        else
            state <= next_state;
    end

    // FSM next-state: RUN until an event, DRAIN for DRAIN_CYCLES, DONE forever.
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (evt_fire)   next_state = DRAIN;
            DRAIN:   if (drain_last) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        halted    = (state == DONE);
        good_trap = halted && (exit_code == 8'h00);
    end

    // Drain timer, counts cycles spent in DRAIN.
    always_ff @(posedge clk) begin
        if (!reset)
            drain_cnt <= '0;
        else if (state == DRAIN)
            drain_cnt <= drain_cnt + DW'(1);
        else
            drain_cnt <= '0;
    end

    // Run-time counters; the event cycle itself is still counted, then they freeze.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            last_pc   <= '0;
            idle_cnt  <= '0;
        end else if (in_run) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (commit_valid) begin
                instr_cnt <= instr_cnt + 64'd1;
                last_pc   <= commit_pc;
                idle_cnt  <= '0;
            end else if (idle_cnt != IW'(HANG_LIMIT)) begin
                idle_cnt  <= idle_cnt + IW'(1);
            end
        end
    end

    // Exit record captured on the event cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exit_cause <= '0;
            exit_code  <= '0;
            exit_pc    <= '0;
        end else if (evt_fire) begin
            exit_cause <= evt_cause;
            exit_code  <= code_sel;
            exit_pc    <= commit_valid ? commit_pc : last_pc;
        end
    end

`ifdef YSYX_25030077_SIM_FINISH_EN
    // Report and end the simulation on the cycle that enters DONE.
    always @(posedge clk) begin
        if (reset && state == DRAIN && next_state == DONE) begin
            $display("sim_monitor: cause=%0d exit_code=0x%02h exit_pc=0x%h cycles=%0d instrs=%0d",
                     exit_cause, exit_code, exit_pc, cycle_cnt, instr_cnt);
            if (exit_code == 8'h00)
                $display("HIT GOOD TRAP");
            else
                $display("HIT BAD TRAP");
            $finish;
        end
    end
`else
    // Synthesizable build: the block simply halts and holds its outputs.
`endif

endmodule

// File: tb/tb_ysyx_25030077_sim_monitor.sv
// Randomized + directed bench for ysyx_25030077_sim_monitor against a cycle-index model.
module tb_ysyx_25030077_sim_monitor;

    localparam int XLEN = 32;
    localparam int NS   = 2;
    localparam int HL   = 16;
    localparam int DC   = 4;
    localparam int CW   = $clog2(NS + 3);

    logic            clk = 1'b0;
    logic            reset;
    logic            commit_valid;
    logic [31:0]     commit_pc;
    logic [31:0]     a0_value;
    logic [NS-1:0]   trap_req;
    logic [63:0]     max_cycles;
    logic            halted;
    logic            good_trap;
    logic [CW-1:0]   exit_cause;
    logic [7:0]      exit_code;
    logic [31:0]     exit_pc;
    logic [63:0]     cycle_cnt;
    logic [63:0]     instr_cnt;

    ysyx_25030077_sim_monitor #(
        .XLEN(XLEN), .NUM_SRC(NS), .HANG_LIMIT(HL), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .a0_value(a0_value), .trap_req(trap_req), .max_cycles(max_cycles),
        .halted(halted), .good_trap(good_trap), .exit_cause(exit_cause),
        .exit_code(exit_code), .exit_pc(exit_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: indices of cycles, not a state machine.
    longint     m_t;        // RUN cycles counted so far
    longint     m_abs;      // cycles since reset released
    longint     m_ev;       // absolute index of the exit event
    longint     m_instr;
    longint     m_lastc;    // RUN index of the last commit (-1: none since reset)
    bit         m_fired;
    int         m_cause;
    logic [7:0] m_code;
    logic [31:0] m_pc, m_lastpc;

    task automatic model_step();
        int c;
        c = 0;
        if (!reset) begin
            m_t = 0; m_abs = 0; m_ev = 0; m_instr = 0; m_lastc = -1; m_fired = 0;
            m_cause = 0; m_code = 8'h00; m_pc = '0; m_lastpc = '0;
            return;
        end
        if (!m_fired) begin
            for (int i = NS - 1; i >= 0; i--)
                if (trap_req[i]) c = i + 1;
            if (c == 0 && max_cycles != 64'd0 && 64'(m_t + 1) == max_cycles) c = NS + 1;
            if (c == 0 && !commit_valid && (m_t - m_lastc) == HL) c = NS + 2;
            if (c != 0) begin
                m_fired = 1;
                m_ev    = m_abs;
                m_cause = c;
                m_pc    = commit_valid ? commit_pc : m_lastpc;
                if (c == 1)            m_code = a0_value[7:0];
                else if (c <= NS)      m_code = 8'hFF;
                else if (c == NS + 1)  m_code = 8'hFE;
                else                   m_code = 8'hFD;
            end
            if (commit_valid) begin
                m_instr++;
                m_lastc  = m_t;
                m_lastpc = commit_pc;
            end
            m_t++;
        end
        m_abs++;
    endtask

    task automatic check_out();
        bit h;
        h = m_fired && (m_abs >= m_ev + DC + 1);
        chk("halted",    64'(halted),    64'(h));
        chk("good_trap", 64'(good_trap), 64'(h && m_code == 8'h00));
        chk("cycle_cnt", cycle_cnt,      64'(m_t));
        chk("instr_cnt", instr_cnt,      64'(m_instr));
        if (h || !m_fired) begin
            chk("exit_cause", 64'(exit_cause), h ? 64'(m_cause) : 64'd0);
            chk("exit_code",  64'(exit_code),  h ? 64'(m_code)  : 64'd0);
            chk("exit_pc",    64'(exit_pc),    h ? 64'(m_pc)    : 64'd0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic drive(input logic cv, input logic [31:0] pc, input logic [31:0] a0,
                         input logic [NS-1:0] tr);
        commit_valid = cv;
        commit_pc    = pc;
        a0_value     = a0;
        trap_req     = tr;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, '0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        max_cycles = 64'd0;
        drive(1'b0, 32'h0, 32'h0, '0);

        // 1. ebreak, good trap
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h8000_0000 + 32'(4 * k), 32'(k + 1), '0);
            tick();
        end
        drive(1'b1, 32'h8000_0028, 32'h0, 2'b01);
        tick();
        drive(1'b0, 32'h0, 32'h7, '0);
        repeat (3) tick();
        chk("t1_not_yet_halted", 64'(halted), 64'd0);
        tick();
        chk("t1_halted",   64'(halted),     64'd1);
        chk("t1_good",     64'(good_trap),  64'd1);
        chk("t1_cause",    64'(exit_cause), 64'd1);
        chk("t1_pc",       64'(exit_pc),    64'h8000_0028);
        chk("t1_instr",    instr_cnt,       64'd11);

        // 2. ebreak, bad trap
        do_reset();
        repeat (3) begin drive(1'b1, 32'h8000_0010, 32'h1, '0); tick(); end
        drive(1'b1, 32'h8000_0014, 32'h2A, 2'b01);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b11);
        repeat (4) tick();
        chk("t2_code", 64'(exit_code), 64'h2A);
        chk("t2_good", 64'(good_trap), 64'd0);

        // 3. unknown instruction, no commit on the event cycle
        do_reset();
        drive(1'b1, 32'h8000_0100, 32'h0, '0);
        tick();
        drive(1'b0, 32'h8000_0104, 32'h0, 2'b10);
        tick();
        drive(1'b0, 32'h0, 32'h0, '0);
        repeat (4) tick();
        chk("t3_cause", 64'(exit_cause), 64'd2);
        chk("t3_code",  64'(exit_code),  64'hFF);
        chk("t3_pc",    64'(exit_pc),    64'h8000_0100);

        // 4. timeout
        do_reset();
        max_cycles = 64'd100;
        for (int k = 0; k < 104; k++) begin
            drive(1'b1, 32'h8000_0000 + 32'(4 * k), 32'h0, '0);
            tick();
        end
        chk("t4_cause", 64'(exit_cause), 64'(NS + 1));
        chk("t4_code",  64'(exit_code),  64'hFE);
        chk("t4_cycle", cycle_cnt,       64'd100);
        max_cycles = 64'd0;

        // 5. hang: a 15-cycle gap survives, a 16-cycle gap does not
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 32'h8000_0000 + 32'(4 * k), 32'h0, '0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, '0);
        repeat (15) tick();
        drive(1'b1, 32'h8000_0040, 32'h0, '0);
        tick();
        drive(1'b0, 32'h0, 32'h0, '0);
        repeat (16) tick();
        chk("t5_gap_not_halted", 64'(halted), 64'd0);
        repeat (4) tick();
        chk("t5_halted", 64'(halted),     64'd1);
        chk("t5_cause",  64'(exit_cause), 64'(NS + 2));
        chk("t5_code",   64'(exit_code),  64'hFD);
        chk("t5_pc",     64'(exit_pc),    64'h8000_0040);
        chk("t5_cycle",  cycle_cnt,       64'd48);

        // 6a. both traps plus timeout in one cycle: channel 0 wins
        do_reset();
        max_cycles = 64'd10;
        repeat (9) begin drive(1'b1, 32'h8000_0200, 32'h0, '0); tick(); end
        drive(1'b1, 32'h8000_0204, 32'h55, 2'b11);
        tick();
        drive(1'b0, 32'h0, 32'h0, '0);
        repeat (4) tick();
        chk("t6_cause", 64'(exit_cause), 64'd1);
        chk("t6_code",  64'(exit_code),  64'h55);

        // 6b. same event, reset in the middle of DRAIN
        do_reset();
        repeat (9) begin drive(1'b1, 32'h8000_0200, 32'h0, '0); tick(); end
        drive(1'b1, 32'h8000_0204, 32'h55, 2'b11);
        tick();
        drive(1'b0, 32'h0, 32'h0, '0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("t6_rst_cause", 64'(exit_cause), 64'd0);
        chk("t6_rst_cycle", cycle_cnt,       64'd0);
        reset = 1'b1;
        max_cycles = 64'd0;
        repeat (3) begin drive(1'b1, 32'h8000_0300, 32'h0, '0); tick(); end
        chk("t6_run_cycle", cycle_cnt, 64'd3);
        chk("t6_run_instr", instr_cnt, 64'd3);
        repeat (6) tick();
        chk("t6_run_no_halt", 64'(halted), 64'd0);

        // Random runs, checked every cycle against the model
        for (int run = 0; run < 40; run++) begin
            int p;
            do_reset();
            max_cycles = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(5, 150));
            p = $urandom_range(0, 100);
            for (int cyc = 0; cyc < 200; cyc++) begin
                logic          cv;
                logic [NS-1:0] tr;
                logic [31:0]   a0;
                cv = ($urandom_range(0, 99) < p);
                tr = ($urandom_range(0, 149) == 0) ? NS'($urandom) : '0;
                a0 = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
                drive(cv, 32'($urandom), a0, tr);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
